// File: rtl/hrm_control_unit_pkg.sv
// Shared encodings for the HRM control unit: opcodes, ALU controls, R-source
// selects and the sequencer state type.
package hrm_pkg;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPP    = 4'h6;
  localparam logic [3:0] OP_BUMPN    = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_BUMPP = 2'b10;
  localparam logic [1:0] ALU_BUMPN = 2'b11;

  // alu_ctl[2]: which condition the ALU reports on its flag output
  localparam logic FLAG_Z = 1'b0;
  localparam logic FLAG_N = 1'b1;

  localparam logic [1:0] R_SEL_ALU   = 2'd0;
  localparam logic [1:0] R_SEL_INBOX = 2'd1;
  localparam logic [1:0] R_SEL_MEM   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_INDIR, S_EXEC, S_WAIT_IN, S_WAIT_OUT, S_HALT
  } state_t;

  function automatic logic [2:0] alu_code(input logic flag_sel, input logic [1:0] op);
    return {flag_sel, op};
  endfunction

endpackage

// File: rtl/hrm_control_unit_if.sv
// Bus between the control unit (master) and ROM / data memory / datapath (slave).
interface hrm_control_unit_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] prog_data;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              mem_wsel;
  logic [2:0]        alu_ctl;
  logic              alu_flag;
  logic              r_load;
  logic [1:0]        r_sel;
  logic              inbox_valid;
  logic              inbox_rd;
  logic              outbox_ready;
  logic              outbox_wr;
  logic              halted;

  modport master (
    input  prog_data, mem_rdata, alu_flag, inbox_valid, outbox_ready,
    output pc, mem_addr, mem_we, mem_wsel, alu_ctl, r_load, r_sel,
           inbox_rd, outbox_wr, halted
  );

  modport slave (
    output prog_data, mem_rdata, alu_flag, inbox_valid, outbox_ready,
    input  pc, mem_addr, mem_we, mem_wsel, alu_ctl, r_load, r_sel,
           inbox_rd, outbox_wr, halted
  );
endinterface

// File: rtl/hrm_control_unit_decoder.sv
// Combinational opcode decode: instruction class flags plus the EXEC-cycle
// strobe templates the sequencer applies.
module hrm_decoder
  import hrm_pkg::*;
(
  input  logic [3:0] i_op,
  output logic       o_needs_operand,
  output logic       o_is_jump,
  output logic       o_is_mem,
  output logic       o_is_in,
  output logic       o_is_out,
  output logic       o_is_halt,
  output logic [2:0] o_alu_ctl,
  output logic       o_r_load,
  output logic [1:0] o_r_sel,
  output logic       o_mem_we,
  output logic       o_mem_wsel
);

  always_comb begin
    o_needs_operand = 1'b0;
    o_is_jump       = 1'b0;
    o_is_mem        = 1'b0;
    o_is_in         = 1'b0;
    o_is_out        = 1'b0;
    o_is_halt       = 1'b0;
    o_alu_ctl       = alu_code(FLAG_Z, ALU_ADD);
    o_r_load        = 1'b0;
    o_r_sel         = R_SEL_ALU;
    o_mem_we        = 1'b0;
    o_mem_wsel      = 1'b0;
    case (i_op)
      OP_INBOX:  o_is_in  = 1'b1;
      OP_OUTBOX: o_is_out = 1'b1;
      OP_COPYFROM: begin
        o_needs_operand = 1'b1;
        o_is_mem        = 1'b1;
        o_r_load        = 1'b1;
        o_r_sel         = R_SEL_MEM;
      end
      OP_COPYTO: begin
        o_needs_operand = 1'b1;
        o_is_mem        = 1'b1;
        o_mem_we        = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        o_needs_operand = 1'b1;
        o_is_mem        = 1'b1;
        o_alu_ctl       = alu_code(FLAG_Z, (i_op == OP_ADD) ? ALU_ADD : ALU_SUB);
        o_r_load        = 1'b1;
      end
      OP_BUMPP, OP_BUMPN: begin
        o_needs_operand = 1'b1;
        o_is_mem        = 1'b1;
        o_alu_ctl       = alu_code(FLAG_Z, (i_op == OP_BUMPP) ? ALU_BUMPP : ALU_BUMPN);
        o_r_load        = 1'b1;
        o_mem_we        = 1'b1;
        o_mem_wsel      = 1'b1;
      end
      OP_JUMP, OP_JUMPZ: begin
        o_needs_operand = 1'b1;
        o_is_jump       = 1'b1;
      end
      OP_JUMPN: begin
        o_needs_operand = 1'b1;
        o_is_jump       = 1'b1;
        o_alu_ctl       = alu_code(FLAG_N, ALU_ADD);
      end
      // HALT and the unused opcodes B-E all stop the machine
      default: o_is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/hrm_control_unit.sv
// HRM sequencer: fetches from program ROM, resolves indirection and jumps,
// and drives one-cycle strobes to data memory, R, ALU and the in/out FIFOs.
module hrm_control_unit
  import hrm_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  hrm_control_unit_if.master bus
);

  state_t              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  logic [DATA_W-1:0]   r_ir, w_ir_nxt;
  logic [DATA_W-1:0]   r_opr, w_opr_nxt;
  logic [DATA_W-1:0]   r_ea, w_ea_nxt;

  logic [3:0] w_op;
  logic       w_needs_operand, w_is_jump, w_is_mem, w_is_in, w_is_out, w_is_halt;
  logic [2:0] w_alu_ctl;
  logic       w_r_load, w_mem_we, w_mem_wsel;
  logic [1:0] w_r_sel;

  // In FETCH the opcode has not been latched yet, so decode the ROM byte directly
  assign w_op = (r_state == S_FETCH) ? bus.prog_data[7:4] : r_ir[7:4];

  hrm_decoder u_dec (
    .i_op            (w_op),
    .o_needs_operand (w_needs_operand),
    .o_is_jump       (w_is_jump),
    .o_is_mem        (w_is_mem),
    .o_is_in         (w_is_in),
    .o_is_out        (w_is_out),
    .o_is_halt       (w_is_halt),
    .o_alu_ctl       (w_alu_ctl),
    .o_r_load        (w_r_load),
    .o_r_sel         (w_r_sel),
    .o_mem_we        (w_mem_we),
    .o_mem_wsel      (w_mem_wsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_opr   <= '0;
      r_ea    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_opr   <= w_opr_nxt;
      r_ea    <= w_ea_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_opr_nxt     = r_opr;
    w_ea_nxt      = r_ea;
    bus.mem_addr  = r_ea;
    bus.alu_ctl   = 3'b000;
    bus.r_load    = 1'b0;
    bus.r_sel     = R_SEL_ALU;
    bus.mem_we    = 1'b0;
    bus.mem_wsel  = 1'b0;
    bus.inbox_rd  = 1'b0;
    bus.outbox_wr = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_nxt = bus.prog_data;
        w_pc_nxt = r_pc + PC_W'(1);
        if (w_is_in)        w_state_nxt = S_WAIT_IN;
        else if (w_is_out)  w_state_nxt = S_WAIT_OUT;
        else if (w_is_halt) w_state_nxt = S_HALT;
        else                w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_opr_nxt   = bus.prog_data;
        w_ea_nxt    = bus.prog_data;
        w_pc_nxt    = r_pc + PC_W'(1);
        w_state_nxt = (w_is_mem && r_ir[3]) ? S_INDIR : S_EXEC;
      end
      S_INDIR: begin
        bus.mem_addr = r_opr;
        w_ea_nxt     = bus.mem_rdata;
        w_state_nxt  = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_ctl  = w_alu_ctl;
        bus.r_load   = w_r_load;
        bus.r_sel    = w_r_sel;
        bus.mem_we   = w_mem_we;
        bus.mem_wsel = w_mem_wsel;
        if (w_is_jump && (r_ir[7:4] == OP_JUMP || bus.alu_flag))
          w_pc_nxt = PC_W'(r_opr);
        w_state_nxt = S_FETCH;
      end
      S_WAIT_IN: begin
        bus.inbox_rd = bus.inbox_valid;
        bus.r_load   = bus.inbox_valid;
        bus.r_sel    = R_SEL_INBOX;
        if (bus.inbox_valid) w_state_nxt = S_FETCH;
      end
      S_WAIT_OUT: begin
        bus.outbox_wr = bus.outbox_ready;
        if (bus.outbox_ready) w_state_nxt = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_HALT;
    endcase
  end

  assign bus.pc     = r_pc;
  assign bus.halted = (r_state == S_HALT);

endmodule

// File: tb/tb_hrm_control_unit.sv
// Directed bench for hrm_control_unit: ROM/data memory modelled as arrays,
// each scenario checks strobes and pc against hand-derived values.
module tb_hrm_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  logic [7:0] rom  [256];
  logic [7:0] dmem [256];

  hrm_control_unit_if #(.PC_W(8), .DATA_W(8)) bus();

  hrm_control_unit #(.PC_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.prog_data = rom[bus.pc];
  assign bus.mem_rdata = dmem[bus.mem_addr];

  // Loads a program, pulses reset, returns at cycle 0 (FETCH of address 0) + 1ns.
  task automatic start(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    rst_n = 1'b0;
    bus.alu_flag = 1'b0;
    bus.inbox_valid = 1'b0;
    bus.outbox_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'hF0;
      dmem[i] = 8'(i);
    end
    rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    start(8'h60, 8'h05, 8'hF0, 8'hF0);
    total++; if (bus.halted !== 1'b0 || bus.pc !== 8'h00) begin bad++; $display("FAIL rst_state: got halted=%b pc=%h exp 0/00", bus.halted, bus.pc); end
    step(2);
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL rst_exec_we: got %b exp 1", bus.mem_we); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_abort_we: got %b exp 0", bus.mem_we); end
    total++; if (bus.pc !== 8'h00 || bus.halted !== 1'b0) begin bad++; $display("FAIL rst_abort_pc: got pc=%h halted=%b exp 00/0", bus.pc, bus.halted); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL rst_release_pc: got %h exp 00", bus.pc); end
    step(1);
    total++; if (bus.pc !== 8'h01) begin bad++; $display("FAIL rst_refetch_pc: got %h exp 01", bus.pc); end
    step(1);
    total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h05) begin bad++; $display("FAIL rst_refetch_exec: got we=%b addr=%h exp 1/05", bus.mem_we, bus.mem_addr); end
  endtask

  task automatic test_io;
    int in_cnt, rl_cnt, out_cnt;
    in_cnt = 0; rl_cnt = 0; out_cnt = 0;
    start(8'h00, 8'h10, 8'hF0, 8'hF0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.inbox_valid  = (k == 4);
      bus.outbox_ready = (k == 8);
      #1;
      if (bus.inbox_rd === 1'b1) in_cnt++;
      if (bus.r_load === 1'b1) rl_cnt++;
      if (bus.outbox_wr === 1'b1) out_cnt++;
      if (k == 4) begin
        total++; if (bus.inbox_rd !== 1'b1 || bus.r_load !== 1'b1 || bus.r_sel !== 2'd1) begin bad++; $display("FAIL io_in_pulse: got rd=%b ld=%b sel=%0d exp 1/1/1", bus.inbox_rd, bus.r_load, bus.r_sel); end
      end
      if (k == 7) begin
        total++; if (bus.outbox_wr !== 1'b0) begin bad++; $display("FAIL io_out_blocked: got %b exp 0", bus.outbox_wr); end
      end
      if (k == 9) begin
        total++; if (bus.pc !== 8'h02) begin bad++; $display("FAIL io_pc: got %h exp 02", bus.pc); end
      end
    end
    bus.inbox_valid = 1'b0;
    bus.outbox_ready = 1'b0;
    total++; if (in_cnt !== 1 || rl_cnt !== 1) begin bad++; $display("FAIL io_in_count: got rd=%0d ld=%0d exp 1/1", in_cnt, rl_cnt); end
    total++; if (out_cnt !== 1) begin bad++; $display("FAIL io_out_count: got %0d exp 1", out_cnt); end
  endtask

  task automatic test_add;
    start(8'h40, 8'h05, 8'hF0, 8'hF0);
    step(1);
    total++; if (bus.r_load !== 1'b0) begin bad++; $display("FAIL add_decode_ld: got %b exp 0", bus.r_load); end
    step(1);
    total++; if (bus.alu_ctl !== 3'b000 || bus.mem_addr !== 8'h05 || bus.r_load !== 1'b1 || bus.r_sel !== 2'd0 || bus.mem_we !== 1'b0)
      begin bad++; $display("FAIL add_exec: got alu=%b addr=%h ld=%b sel=%0d we=%b exp 000/05/1/0/0", bus.alu_ctl, bus.mem_addr, bus.r_load, bus.r_sel, bus.mem_we); end
    step(1);
    total++; if (bus.pc !== 8'h02) begin bad++; $display("FAIL add_pc: got %h exp 02", bus.pc); end
  endtask

  task automatic test_bump_indirect;
    start(8'h68, 8'h03, 8'hF0, 8'hF0);
    dmem[3] = 8'h07;
    step(2);
    total++; if (bus.mem_addr !== 8'h03 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL ind_indir: got addr=%h we=%b exp 03/0", bus.mem_addr, bus.mem_we); end
    step(1);
    total++; if (bus.mem_addr !== 8'h07 || bus.alu_ctl !== 3'b010 || bus.mem_we !== 1'b1 || bus.mem_wsel !== 1'b1 || bus.r_load !== 1'b1 || bus.r_sel !== 2'd0)
      begin bad++; $display("FAIL ind_exec: got addr=%h alu=%b we=%b wsel=%b ld=%b sel=%0d exp 07/010/1/1/1/0", bus.mem_addr, bus.alu_ctl, bus.mem_we, bus.mem_wsel, bus.r_load, bus.r_sel); end
    step(1);
    total++; if (bus.pc !== 8'h02 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL ind_after: got pc=%h we=%b exp 02/0", bus.pc, bus.mem_we); end
  endtask

  task automatic test_jumps;
    start(8'h90, 8'h20, 8'hF0, 8'hF0);
    bus.alu_flag = 1'b1;
    step(2);
    total++; if (bus.alu_ctl !== 3'b000) begin bad++; $display("FAIL jz_alu: got %b exp 000", bus.alu_ctl); end
    step(1);
    total++; if (bus.pc !== 8'h20) begin bad++; $display("FAIL jz_taken: got %h exp 20", bus.pc); end
    start(8'h90, 8'h20, 8'hF0, 8'hF0);
    step(3);
    total++; if (bus.pc !== 8'h02) begin bad++; $display("FAIL jz_not_taken: got %h exp 02", bus.pc); end
    start(8'hA0, 8'h20, 8'hF0, 8'hF0);
    bus.alu_flag = 1'b1;
    step(2);
    total++; if (bus.alu_ctl !== 3'b100) begin bad++; $display("FAIL jn_alu: got %b exp 100", bus.alu_ctl); end
    step(1);
    total++; if (bus.pc !== 8'h20) begin bad++; $display("FAIL jn_taken: got %h exp 20", bus.pc); end
    start(8'h98, 8'h20, 8'hF0, 8'hF0);
    bus.alu_flag = 1'b1;
    step(3);
    total++; if (bus.pc !== 8'h20) begin bad++; $display("FAIL jz_ind_ignored: got %h exp 20", bus.pc); end
  endtask

  task automatic test_halt(input logic [7:0] op);
    int strobes;
    strobes = 0;
    start(op, 8'h40, 8'h05, 8'hF0);
    bus.inbox_valid = 1'b1;
    bus.outbox_ready = 1'b1;
    step(1);
    total++; if (bus.halted !== 1'b1 || bus.pc !== 8'h01) begin bad++; $display("FAIL halt_%h_entry: got halted=%b pc=%h exp 1/01", op, bus.halted, bus.pc); end
    for (int k = 0; k < 10; k++) begin
      step(1);
      if ({bus.mem_we, bus.r_load, bus.inbox_rd, bus.outbox_wr} !== 4'b0000 || bus.pc !== 8'h01 || bus.halted !== 1'b1) strobes++;
    end
    total++; if (strobes !== 0) begin bad++; $display("FAIL halt_%h_frozen: got %0d active cycles exp 0", op, strobes); end
  endtask

  task automatic test_wrap;
    start(8'h80, 8'hFF, 8'hF0, 8'hF0);
    rom[8'hFF] = 8'h40;
    step(3);
    total++; if (bus.pc !== 8'hFF) begin bad++; $display("FAIL wrap_jump: got %h exp ff", bus.pc); end
    step(1);
    total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL wrap_pc: got %h exp 00", bus.pc); end
    step(1);
    total++; if (bus.mem_addr !== 8'h80 || bus.r_load !== 1'b1) begin bad++; $display("FAIL wrap_operand: got addr=%h ld=%b exp 80/1", bus.mem_addr, bus.r_load); end
    step(1);
    total++; if (bus.pc !== 8'h01) begin bad++; $display("FAIL wrap_end_pc: got %h exp 01", bus.pc); end
  endtask

  task automatic test_back_to_back;
    start(8'h40, 8'h05, 8'h50, 8'h06);
    step(2);
    total++; if (bus.alu_ctl !== 3'b000 || bus.mem_addr !== 8'h05) begin bad++; $display("FAIL b2b_add: got alu=%b addr=%h exp 000/05", bus.alu_ctl, bus.mem_addr); end
    step(3);
    total++; if (bus.alu_ctl !== 3'b001 || bus.mem_addr !== 8'h06 || bus.r_load !== 1'b1) begin bad++; $display("FAIL b2b_sub: got alu=%b addr=%h ld=%b exp 001/06/1", bus.alu_ctl, bus.mem_addr, bus.r_load); end
    step(1);
    total++; if (bus.pc !== 8'h04) begin bad++; $display("FAIL b2b_pc: got %h exp 04", bus.pc); end
  endtask

  initial begin
    test_reset;
    test_io;
    test_add;
    test_bump_indirect;
    test_jumps;
    test_halt(8'hB0);
    test_halt(8'hF0);
    test_wrap;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hrm_control_unit.md
Name: hrm_control_unit

Overview:
- Sequencer on the driving side of the HRM ALU. It fetches instructions from program memory, holds PC and IR, and issues `alu_ctl`, register, memory and inbox/outbox strobes to the datapath.
- Consumes the ALU `flag` to resolve the conditional jumps JUMPZ and JUMPN.
- Sits between program ROM, data memory and the datapath (R register, ALU, inbox/outbox FIFOs).

Parameters:
- PC_W, 8, program counter / program address width
- DATA_W, 8, data and address byte width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- prog_data  in  8  program memory byte at `pc`; combinational read
- pc  out  PC_W  program address
- mem_addr  out  8  data memory address (operand or indirect effective address)
- mem_rdata  in  8  data memory read data; combinational read, used for indirection
- mem_we  out  1  data memory write strobe
- mem_wsel  out  1  write data select: 0 = R, 1 = ALU out
- alu_ctl  out  3  ALU control
- alu_flag  in  1  ALU flag
- r_load  out  1  load R register
- r_sel  out  2  R source: 0 = ALU, 1 = inbox, 2 = memory
- inbox_valid  in  1  inbox has data
- inbox_rd  out  1  pop inbox
- outbox_ready  in  1  outbox can accept
- outbox_wr  out  1  push R to outbox
- halted  out  1  CPU stopped

Behaviour:
- **ALU encoding.**
  - `alu_ctl[1:0]`: 00 ADD (R+M), 01 SUB (R-M), 10 BUMP+ (M+1), 11 BUMP- (M-1).
  - `alu_ctl[2]` selects the flag: 0 → flag = (R==0), 1 → flag = (R<0, signed).
- **Instruction format.**
  - Byte0: [7:4] opcode, [3] indirect, [2:0] ignored.
  - Opcodes: 0 INBOX, 1 OUTBOX, 2 COPYFROM, 3 COPYTO, 4 ADD, 5 SUB, 6 BUMP+, 7 BUMP-, 8 JUMP, 9 JUMPZ, A JUMPN, F HALT. B–E are illegal and behave as HALT.
  - Opcodes 2–A take an operand byte (Byte1). Opcodes 0, 1 and F are single-byte.
- **States:** FETCH, DECODE, INDIR, EXEC, WAIT_IN, WAIT_OUT, HALT.
  - FETCH: IR ← `prog_data`, pc ← pc+1.
    - Opcode 0 → WAIT_IN; 1 → WAIT_OUT; F or B–E → HALT; otherwise → DECODE.
  - DECODE: OPR ← `prog_data`, pc ← pc+1.
    - Jumps, or memory ops with indirect=0 → EXEC.
    - Memory ops with indirect=1 → INDIR.
    - EA ← operand.
  - INDIR: `mem_addr` = OPR; EA ← `mem_rdata`; → EXEC. The indirect bit is ignored on jumps.
  - EXEC: `mem_addr` = EA for one cycle, then → FETCH.
    - COPYFROM: `r_load`=1, `r_sel`=2.
    - COPYTO: `mem_we`=1, `mem_wsel`=0.
    - ADD/SUB: `alu_ctl`=000/001, `r_load`=1, `r_sel`=0.
    - BUMP+/BUMP-: `alu_ctl`=010/011, `r_load`=1, `r_sel`=0, `mem_we`=1, `mem_wsel`=1.
    - JUMP: pc ← OPR.
    - JUMPZ: `alu_ctl`=000, pc ← OPR if `alu_flag`, else unchanged.
    - JUMPN: `alu_ctl`=100, same rule as JUMPZ.
  - WAIT_IN: `inbox_rd` = `inbox_valid`; `r_load` = `inbox_valid`; `r_sel`=1. → FETCH when `inbox_valid`, else stay.
  - WAIT_OUT: `outbox_wr` = `outbox_ready`. → FETCH when `outbox_ready`, else stay.
  - HALT: terminal; `halted`=1. Only reset exits HALT.
- **Strobe timing.** All strobes are decoded from state/IR/EA. Only `inbox_rd`/`outbox_wr` (and `r_load` in WAIT_IN) depend combinationally on the handshake inputs. Every strobe is a single-cycle pulse per transfer.
- **Latency.**
  - INBOX/OUTBOX: 2 cycles minimum.
  - Direct operand ops: 3 cycles.
  - Indirect operand ops: 4 cycles.
- **Idle values.** When not active: `alu_ctl`=000, `mem_addr`=EA, other strobes 0.
- **Reset (asynchronous).**
  - pc=0, IR=0, OPR=0, EA=0, state=FETCH, `halted`=0, all strobes 0.
  - Reset asserted mid-instruction aborts it with no partial write.
- **Wrap-around.** pc is modulo 2^PC_W, so 0xFF+1 = 0x00. An operand fetch at 0xFF reads address 0x00.

Decomposition:
- Package `hrm_pkg`:
  - opcode constants
  - ALU_ADD/SUB/BUMPP/BUMPN
  - FLAG_Z/FLAG_N bit meanings
  - R_SEL_* codes
  - state encoding
- Sub-module `hrm_decoder`, combinational. Maps opcode to `needs_operand`, `is_jump`, `is_mem`, `alu_ctl`, `r_load`, `mem_we` and `mem_wsel` templates.

Test Plan:
- Reset: assert `rst_n`=0 during EXEC of a BUMP+ → `mem_we` drops immediately, pc=0, `halted`=0. After release, first FETCH reads address 0.
- Program 00,10 (INBOX, OUTBOX):
  - `inbox_valid` rises 3 cycles late → exactly one `inbox_rd`/`r_load` pulse with `r_sel`=1.
  - `outbox_ready` held low 2 cycles → `outbox_wr` single pulse when ready, then pc=2.
- Program 40,05 (ADD 5) → in cycle 3: `alu_ctl`=000, `mem_addr`=05, `r_load`=1, `r_sel`=0. pc=2 afterwards.
- Program 68,03 with mem[03]=07 (BUMP+ indirect) → INDIR `mem_addr`=03. EXEC: `mem_addr`=07, `alu_ctl`=010, `mem_we`=1, `mem_wsel`=1, `r_load`=1.
- Program 90,20 (JUMPZ 0x20):
  - `alu_flag`=1 → pc=20; `alu_flag`=0 → pc=02.
  - Program A0,20 (JUMPN) → `alu_ctl`=100 in EXEC.
- Byte B0 or F0 → `halted`=1 after FETCH, pc frozen, no strobes for 10 cycles.
- Program 80,FF (JUMP 0xFF) with 40 at 0xFF → the ADD takes its operand from address 0x00, and pc ends at 0x01.
